// File: rtl/prog_loader.sv
// Host-side program/data loader: streams words into I-MEM/D-MEM, gates pipeline reset.
// Optional running XOR of loaded words when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_sel,
    input  logic [8:0]  cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [63:0] data_in,
    input  logic        run_req,
    input  logic        halt_req,
    output logic        imem_we,
    output logic [8:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        dmem_we,
    output logic [7:0]  dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic        pipe_hold,
    output logic        done,
    output logic        err,
    output logic [63:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q;
    logic [8:0]  ptr_q;
    logic [8:0]  cnt_q;
    logic        imem_we_q;
    logic [8:0]  imem_addr_q;
    logic [31:0] imem_wdata_q;
    logic        dmem_we_q;
    logic [7:0]  dmem_addr_q;
    logic [63:0] dmem_wdata_q;
    logic        err_q;

    logic        cmd_hs;
    logic        data_hs;
    logic        bad_cmd;
    logic [9:0]  range_end;

    assign cmd_ready  = (state_q == IDLE);
    assign data_ready = (state_q == LOAD);
    assign pipe_hold  = (state_q != RUN);
    assign done       = (state_q == DONE);
    assign err        = err_q;

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign data_hs = data_valid && data_ready;

    // End of range is one past the last word, so equal to depth is still legal.
    assign range_end = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign bad_cmd   = cmd_sel ? (cmd_addr[8] || (range_end > 10'd256))
                               : (range_end > 10'd512);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (!bad_cmd) begin
                        state_d = (cmd_len == 9'd0) ? DONE : LOAD;
                    end
                end else if (run_req) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (data_hs && (cnt_q == 9'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            RUN: begin
                if (halt_req) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q        <= 1'b0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q     <= cmd_hs && bad_cmd;
            imem_we_q <= data_hs && !sel_q;
            dmem_we_q <= data_hs && sel_q;
            if (cmd_hs && !bad_cmd) begin
                sel_q <= cmd_sel;
                ptr_q <= cmd_addr;
                cnt_q <= cmd_len;
            end
            if (data_hs) begin
                if (sel_q) begin
                    dmem_addr_q  <= ptr_q[7:0];
                    dmem_wdata_q <= data_in;
                end else begin
                    imem_addr_q  <= ptr_q;
                    imem_wdata_q <= data_in[31:0];
                end
                ptr_q <= ptr_q + 9'd1;
                cnt_q <= cnt_q - 9'd1;
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [63:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (cmd_hs) begin
            csum_q <= '0;
        end else if (data_hs) begin
            csum_q <= csum_q ^ data_in;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Expected checksum follows PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_sel;
    logic [8:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic        data_valid;
    logic        data_ready;
    logic [63:0] data_in;
    logic        run_req;
    logic        halt_req;
    logic        imem_we;
    logic [8:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic        pipe_hold;
    logic        done;
    logic        err;
    logic [63:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .pipe_hold  (pipe_hold),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic sel, input logic [8:0] addr,
                            input logic [8:0] len);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({imem_we, dmem_we, done, err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_strobes got %b want 0000",
                     {imem_we, dmem_we, done, err});
        end
        n_cmp++;
        if ({pipe_hold, cmd_ready, data_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b want 110",
                     {pipe_hold, cmd_ready, data_ready});
        end
        n_cmp++;
        if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata, checksum} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got nonzero want 0");
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_imem_load;
        logic [63:0] w;
        send_cmd(1'b0, 9'd0, 9'd4);
        n_cmp++;
        if ({cmd_ready, data_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL imem_enter_load got %b want 01", {cmd_ready, data_ready});
        end
        for (int i = 0; i < 4; i++) begin
            w = {32'hDEAD_0000 + 32'(i), 32'h11 * 32'(i + 1)};
            data_valid = 1'b1;
            data_in    = w;
            tick();
            n_cmp++;
            if ({imem_we, dmem_we, imem_addr, imem_wdata} !==
                {2'b10, 9'(i), 32'h11 * 32'(i + 1)}) begin
                n_bad++;
                $display("FAIL imem_write%0d got we=%b/%b a=%0d d=%h", i,
                         imem_we, dmem_we, imem_addr, imem_wdata);
            end
            n_cmp++;
            if (done !== (i == 3)) begin
                n_bad++;
                $display("FAIL imem_done%0d got %b want %b", i, done, i == 3);
            end
        end
        data_valid = 1'b0;
        tick();
        n_cmp++;
        if ({cmd_ready, imem_we, done} !== 3'b100) begin
            n_bad++;
            $display("FAIL imem_after got %b want 100", {cmd_ready, imem_we, done});
        end
    endtask

    task automatic test_dmem_gap;
        send_cmd(1'b1, 9'h0FE, 9'd2);
        data_valid = 1'b1;
        data_in    = 64'hA5A5_0000_1111_2222;
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({dmem_we, imem_we, dmem_addr, dmem_wdata, done} !==
            {2'b10, 8'hFE, 64'hA5A5_0000_1111_2222, 1'b0}) begin
            n_bad++;
            $display("FAIL dmem_w0 got we=%b/%b a=%h d=%h done=%b",
                     dmem_we, imem_we, dmem_addr, dmem_wdata, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({dmem_we, imem_we, data_ready} !== 3'b001) begin
                n_bad++;
                $display("FAIL dmem_gap%0d got %b want 001", i,
                         {dmem_we, imem_we, data_ready});
            end
        end
        data_valid = 1'b1;
        data_in    = 64'h5A5A_3333_4444_5555;
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({dmem_we, imem_we, dmem_addr, dmem_wdata, done} !==
            {2'b10, 8'hFF, 64'h5A5A_3333_4444_5555, 1'b1}) begin
            n_bad++;
            $display("FAIL dmem_w1 got we=%b/%b a=%h d=%h done=%b",
                     dmem_we, imem_we, dmem_addr, dmem_wdata, done);
        end
        tick();
    endtask

    task automatic test_range;
        send_cmd(1'b1, 9'h0FF, 9'd2);
        n_cmp++;
        if ({err, cmd_ready, data_ready, dmem_we, imem_we} !== 5'b11000) begin
            n_bad++;
            $display("FAIL range_dmem_over got %b want 11000",
                     {err, cmd_ready, data_ready, dmem_we, imem_we});
        end
        tick();
        n_cmp++;
        if ({err, cmd_ready, dmem_we} !== 3'b010) begin
            n_bad++;
            $display("FAIL range_err_pulse got %b want 010", {err, cmd_ready, dmem_we});
        end
        send_cmd(1'b1, 9'h100, 9'd0);
        n_cmp++;
        if ({err, cmd_ready, done} !== 3'b110) begin
            n_bad++;
            $display("FAIL range_dmem_bit8 got %b want 110", {err, cmd_ready, done});
        end
        send_cmd(1'b0, 9'd510, 9'd2);
        n_cmp++;
        if ({err, data_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL range_imem_edge got %b want 01", {err, data_ready});
        end
        data_valid = 1'b1;
        data_in    = 64'h0;
        tick();
        data_in = 64'h1;
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata, done} !== {1'b1, 9'd511, 32'h1, 1'b1}) begin
            n_bad++;
            $display("FAIL range_imem_last got we=%b a=%0d d=%h done=%b",
                     imem_we, imem_addr, imem_wdata, done);
        end
        tick();
    endtask

    task automatic test_len0_run;
        send_cmd(1'b0, 9'd5, 9'd0);
        n_cmp++;
        if ({done, imem_we, dmem_we, data_ready} !== 4'b1000) begin
            n_bad++;
            $display("FAIL len0_done got %b want 1000",
                     {done, imem_we, dmem_we, data_ready});
        end
        tick();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        n_cmp++;
        if ({pipe_hold, cmd_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL run_enter got %b want 00", {pipe_hold, cmd_ready});
        end
        cmd_valid = 1'b1;
        cmd_len   = 9'd1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({pipe_hold, data_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL run_cmd_ignored got %b want 00", {pipe_hold, data_ready});
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_cmp++;
        if ({pipe_hold, cmd_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL halt got %b want 11", {pipe_hold, cmd_ready});
        end
    endtask

    task automatic test_cmd_priority;
        run_req = 1'b1;
        send_cmd(1'b1, 9'd0, 9'd1);
        run_req = 1'b0;
        n_cmp++;
        if ({pipe_hold, data_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL cmd_priority got %b want 11", {pipe_hold, data_ready});
        end
        data_valid = 1'b1;
        data_in    = 64'h77;
        tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload;
        send_cmd(1'b0, 9'd8, 9'd5);
        data_valid = 1'b1;
        data_in    = 64'h100;
        tick();
        data_in = 64'h101;
        tick();
        n_cmp++;
        if ({imem_we, imem_addr} !== {1'b1, 9'd9}) begin
            n_bad++;
            $display("FAIL midload_w1 got we=%b a=%0d want 1/9", imem_we, imem_addr);
        end
        data_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({imem_we, dmem_we, pipe_hold, cmd_ready, data_ready, done} !== 6'b001100) begin
            n_bad++;
            $display("FAIL midload_reset got %b want 001100",
                     {imem_we, dmem_we, pipe_hold, cmd_ready, data_ready, done});
        end
        tick();
        reset = 1'b1;
        tick();
        send_cmd(1'b1, 9'd3, 9'd1);
        n_cmp++;
        if ({data_ready, err} !== 2'b10) begin
            n_bad++;
            $display("FAIL midload_new_cmd got %b want 10", {data_ready, err});
        end
        data_valid = 1'b1;
        data_in    = 64'h9;
        tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic test_checksum;
        logic [63:0] exp;
`ifdef PROG_LOADER_CHECKSUM_EN
        exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp = 64'h0;
`endif
        send_cmd(1'b1, 9'h10, 9'd2);
        data_valid = 1'b1;
        data_in    = 64'hF0F0_F0F0_F0F0_F0F0;
        tick();
        data_in = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        data_valid = 1'b0;
        n_cmp++;
        if ({done, checksum} !== {1'b1, exp}) begin
            n_bad++;
            $display("FAIL checksum_done got done=%b sum=%h want 1/%h",
                     done, checksum, exp);
        end
        tick();
        n_cmp++;
        if (checksum !== exp) begin
            n_bad++;
            $display("FAIL checksum_hold got %h want %h", checksum, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_sel    = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data_in    = '0;
        run_req    = 1'b0;
        halt_req   = 1'b0;
        test_reset();
        test_imem_load();
        test_dmem_gap();
        test_range();
        test_len0_run();
        test_cmd_priority();
        test_reset_midload();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Host-side writer that fills instruction and data memory before the pipeline runs, the write-direction counterpart of the D-MEM verification read port. Accepts a load command (target, base address, word count), then a valid/ready stream of 64-bit words, and issues one memory write per accepted word. Holds the pipeline in reset while loading and releases it on a run request. Sits between the test host and the `pipeline` top, driving the I-MEM and D-MEM write ports.

## Interface
- No parameters. I-MEM depth 512 x 32 and D-MEM depth 256 x 64 are fixed.
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  load command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_sel`  in  1  0 = I-MEM, 1 = D-MEM
- `cmd_addr`  in  9  base word address (D-MEM uses bits [7:0]; bit 8 must be 0)
- `cmd_len`  in  9  word count, 0..511
- `data_valid`  in  1  data word present
- `data_ready`  out  1  high only in LOAD
- `data_in`  in  64  data word; I-MEM takes bits [31:0]
- `run_req`  in  1  release pipeline (IDLE only)
- `halt_req`  in  1  stop pipeline (RUN only)
- `imem_we`  out  1  I-MEM write strobe
- `imem_addr`  out  9  I-MEM write address
- `imem_wdata`  out  32  I-MEM write data
- `dmem_we`  out  1  D-MEM write strobe
- `dmem_addr`  out  8  D-MEM write address
- `dmem_wdata`  out  64  D-MEM write data
- `pipe_hold`  out  1  active-high hold/reset to the pipeline
- `done`  out  1  one-cycle pulse, load complete
- `err`  out  1  one-cycle pulse, command rejected
- `checksum`  out  64  XOR of all words of the last load

## Operation
- States: IDLE, LOAD, DONE, RUN.
- IDLE: `cmd_ready`=1, `pipe_hold`=1. Command handshake (`cmd_valid`&&`cmd_ready`) latches sel/addr/len into registers.
- Range check on accept, computed in 10 bits: reject if `cmd_addr`+`cmd_len` > depth (512 I-MEM, 256 D-MEM) or D-MEM with `cmd_addr[8]`=1. Reject: `err` pulse next cycle, stay IDLE, no writes.
- Accepted with `cmd_len`=0 -> DONE directly. Otherwise -> LOAD, remaining count = `cmd_len`, write pointer = `cmd_addr`.
- LOAD: `data_ready`=1. Each data handshake registers one write to the selected memory at the pointer, then pointer +1, count -1. Count reaching 0 on a handshake -> DONE.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- IDLE with `run_req` (and no command accepted that cycle) -> RUN; `pipe_hold`=0 in RUN. Command wins over `run_req` when both arrive.
- RUN with `halt_req` -> IDLE; `cmd_ready`, `data_ready` are 0 in RUN. `halt_req` ignored outside RUN; `run_req` ignored outside IDLE.
- Only the selected memory's strobe ever asserts; the other stays 0.

## Timing
- Reset (async, `reset`=0): state IDLE; `imem_we`, `dmem_we`, `done`, `err` = 0; addresses/wdata = 0; `checksum` = 0; `pipe_hold` = 1; `cmd_ready` = 1, `data_ready` = 0 (decoded from state).
- Write latency: word accepted at edge N -> strobe, address, data valid cycle N+1, one cycle wide. Back-to-back words give back-to-back strobes, one per cycle.
- Last word accepted at edge N: final strobe and `done` both high cycle N+1; `cmd_ready` high cycle N+2.
- Error: command accepted at edge N -> `err` high cycle N+1; `cmd_ready` stays high.
- RUN entry: `run_req` sampled at edge N -> `pipe_hold` low from cycle N+1. Halt likewise reasserts `pipe_hold` at N+1.
- Reset mid-load: strobes drop immediately; words already written remain in memory; remaining words are lost; no `done`.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined: `checksum` cleared on each command accept, XORed with every accepted 64-bit `data_in` (full width, also for I-MEM loads), stable from the `done` cycle until the next command accept.
- Not defined: no checksum register; `checksum` tied to 0.

## Test plan
- I-MEM load addr 0, len 4, words 0x..11,0x..22,0x..33,0x..44 back-to-back -> `imem_we` 4 consecutive cycles, addr 0..3, wdata low 32 bits; `done` with 4th strobe.
- D-MEM load addr 0xFE, len 2, `data_valid` gap of 3 cycles between words -> writes at 0xFE, 0xFF only on handshake cycles; `imem_we` never asserts.
- D-MEM addr 0xFF, len 2 -> `err` pulse, no strobes, `cmd_ready` remains 1; I-MEM addr 510 len 2 -> accepted.
- len 0 command -> `done` next cycle, no strobes; then `run_req` -> `pipe_hold`=0 next cycle; `halt_req` -> `pipe_hold`=1, `cmd_ready`=1.
- `reset` low after 2 of 5 words -> strobes 0 immediately, `pipe_hold`=1, IDLE; new command accepted after release.
- With `PROG_LOADER_CHECKSUM_EN`, load 0xF0F0..F0, 0x0F0F..0F -> `checksum`=0xFFFF_FFFF_FFFF_FFFF; without it `checksum`=0.
